// File: rtl/operand_fetch_pkg.sv
// Shared pipeline constants and types for the operand-fetch stage.
// Field widths match the decode stage's instruction format.
package operand_fetch_pkg;

    localparam int DEF_REG_SIZE    = 32;
    localparam int DEF_R_FILE_SIZE = 16;
    localparam int REG_IDX_W       = 4;
    localparam int OPCODE_W        = 4;
    localparam int SFT_REG_W       = 8;
    localparam int IMM_W           = 8;
    localparam int SFT_IMM_W       = 4;
    localparam int SHAMT_W         = 5;
    localparam int SHOW_W          = 16;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_LSL = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

endpackage

// File: rtl/operand_shifter.sv
// Combinational second-operand generator.
// It either rotates the zero-extended immediate or barrel-shifts the register operand.
module operand_shifter
    import operand_fetch_pkg::*;
#(
    parameter int W = DEF_REG_SIZE
) (
    input  logic                 imm_or_reg,
    input  logic [IMM_W-1:0]     imm,
    input  logic [SFT_IMM_W-1:0] sft_imm,
    input  shift_t               sh_type,
    input  logic [SHAMT_W-1:0]   sh_amt,
    input  logic [W-1:0]         operand,
    output logic [W-1:0]         result
);

    logic [W-1:0]   imm_ext;
    logic [2*W-1:0] dbl;

    assign imm_ext = {{(W-IMM_W){1'b0}}, imm};

    // Rotations shift a doubled copy so the low half wraps naturally.
    always_comb begin
        result = operand;
        dbl    = '0;
        if (imm_or_reg) begin
            dbl    = {imm_ext, imm_ext} >> {sft_imm, 1'b0};
            result = dbl[W-1:0];
        end else if (sh_amt != '0) begin
            case (sh_type)
                SH_LSR:  result = operand >> sh_amt;
                SH_LSL:  result = operand << sh_amt;
                SH_ASR:  result = W'($signed(operand) >>> sh_amt);
                SH_ROR: begin
                    dbl    = {operand, operand} >> sh_amt;
                    result = dbl[W-1:0];
                end
                default: result = operand;
            endcase
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file with forwarding/write-back bypass,
// operand-2 shifter, and a one-entry output register with valid/ready.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int REG_SIZE    = DEF_REG_SIZE,
    parameter int R_FILE_SIZE = DEF_R_FILE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPCODE_W-1:0]  op_code,
    input  logic [REG_IDX_W-1:0] dest,
    input  logic [REG_IDX_W-1:0] op_reg1,
    input  logic                 imm_or_reg,
    input  logic [REG_IDX_W-1:0] op_reg2,
    input  logic [SFT_REG_W-1:0] sft_reg,
    input  logic [IMM_W-1:0]     imm,
    input  logic [SFT_IMM_W-1:0] sft_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPCODE_W-1:0]  out_op_code,
    output logic [REG_IDX_W-1:0] out_dest,
    output logic [REG_SIZE-1:0]  opr1,
    output logic [REG_SIZE-1:0]  opr2,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [REG_SIZE-1:0]  wb_data,
    input  logic                 fwd_en,
    input  logic [REG_IDX_W-1:0] fwd_dest,
    input  logic [REG_SIZE-1:0]  fwd_data,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] pos_show,
    output logic [SHOW_W-1:0]    show
);

    logic [REG_SIZE-1:0]  rf_q [R_FILE_SIZE];
    logic [REG_SIZE-1:0]  rf_d [R_FILE_SIZE];

    logic                 out_valid_q, out_valid_d;
    logic [OPCODE_W-1:0]  op_code_q, op_code_d;
    logic [REG_IDX_W-1:0] dest_q, dest_d;
    logic [REG_SIZE-1:0]  opr1_q, opr1_d;
    logic [REG_SIZE-1:0]  opr2_q, opr2_d;
    logic [SHOW_W-1:0]    show_q, show_d;

    logic [REG_IDX_W-1:0] rd_idx [3];
    logic [REG_SIZE-1:0]  rd_val [3];
    logic [SHAMT_W-1:0]   sh_amt;
    logic [REG_SIZE-1:0]  shift_res;
    logic                 accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign rd_idx[0] = op_reg1;
    assign rd_idx[1] = op_reg2;
    assign rd_idx[2] = sft_reg[7:4];

    // The execute result is newer than write-back, so it wins on a match.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (rd_idx[i] == '0)
                rd_val[i] = '0;
            else if (fwd_en && fwd_dest == rd_idx[i])
                rd_val[i] = fwd_data;
            else if (wb_en && wb_addr == rd_idx[i])
                rd_val[i] = wb_data;
            else
                rd_val[i] = rf_q[rd_idx[i]];
        end
    end

    assign sh_amt = sft_reg[0] ? rd_val[2][SHAMT_W-1:0] : sft_reg[7:3];

    operand_shifter #(.W(REG_SIZE)) u_shifter (
        .imm_or_reg (imm_or_reg),
        .imm        (imm),
        .sft_imm    (sft_imm),
        .sh_type    (shift_t'(sft_reg[2:1])),
        .sh_amt     (sh_amt),
        .operand    (rd_val[1]),
        .result     (shift_res)
    );

    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_addr != '0)
            rf_d[wb_addr] = wb_data;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        op_code_d   = op_code_q;
        dest_d      = dest_q;
        opr1_d      = opr1_q;
        opr2_d      = opr2_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (accept)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
        if (accept && !flush) begin
            op_code_d = op_code;
            dest_d    = dest;
            opr1_d    = rd_val[0];
            opr2_d    = shift_res;
        end
        show_d = rf_d[pos_show][SHOW_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < R_FILE_SIZE; k++)
                rf_q[k] <= REG_SIZE'(k * 16);
            out_valid_q <= 1'b0;
            op_code_q   <= '0;
            dest_q      <= '0;
            opr1_q      <= '0;
            opr2_q      <= '0;
            show_q      <= '0;
        end else begin
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            op_code_q   <= op_code_d;
            dest_q      <= dest_d;
            opr1_q      <= opr1_d;
            opr2_q      <= opr2_d;
            show_q      <= show_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op_code = op_code_q;
    assign out_dest    = dest_q;
    assign opr1        = opr1_q;
    assign opr2        = opr2_q;
    assign show        = show_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hand-computed vectors checked with
// immediate assertions one cycle after each launch.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  op_code, dest, op_reg1, op_reg2, sft_imm;
    logic        imm_or_reg;
    logic [7:0]  sft_reg, imm;
    logic        out_valid, out_ready;
    logic [3:0]  out_op_code, out_dest;
    logic [31:0] opr1, opr2;
    logic        wb_en, fwd_en, flush;
    logic [3:0]  wb_addr, fwd_dest, pos_show;
    logic [31:0] wb_data, fwd_data;
    logic [15:0] show;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .dest(dest), .op_reg1(op_reg1), .imm_or_reg(imm_or_reg),
        .op_reg2(op_reg2), .sft_reg(sft_reg), .imm(imm), .sft_imm(sft_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_code(out_op_code), .out_dest(out_dest), .opr1(opr1), .opr2(opr2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_en(fwd_en), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .flush(flush), .pos_show(pos_show), .show(show)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 0; out_ready = 1; op_code = 0; dest = 0;
        op_reg1 = 0; op_reg2 = 0; imm_or_reg = 0; sft_reg = 0; imm = 0; sft_imm = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; fwd_en = 0; fwd_dest = 0; fwd_data = 0;
        flush = 0; pos_show = 4'd5;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_opcode", {28'd0, out_op_code}, 32'd0);
        chk("rst_opr1", opr1, 32'd0);
        chk("rst_opr2", opr2, 32'd0);
        chk("rst_show", {16'd0, show}, 32'd0);
        rst = 1'b1;
        step();
        chk("show_r5", {16'd0, show}, 32'h0050);
        pos_show = 4'd3;
        step();
        chk("show_r3", {16'd0, show}, 32'h0030);

        // immediate rotate: 0xFF ror 8
        in_valid = 1; op_code = 4'd5; dest = 4'd7; op_reg1 = 4'd1;
        imm_or_reg = 1; imm = 8'hFF; sft_imm = 4'd4;
        step();
        chk("imm_valid", {31'd0, out_valid}, 32'd1);
        chk("imm_opr2", opr2, 32'hFF000000);
        chk("imm_opr1", opr1, 32'h00000010);
        chk("imm_opcode", {28'd0, out_op_code}, 32'd5);
        chk("imm_dest", {28'd0, out_dest}, 32'd7);
        in_valid = 0;
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        wb_en = 1; wb_addr = 4'd3; wb_data = 32'h80000000;
        step();
        wb_en = 0;

        in_valid = 1; imm_or_reg = 0; op_reg2 = 4'd3; sft_reg = 8'h14;
        step();
        chk("asr2", opr2, 32'hE0000000);
        sft_reg = 8'h20;
        step();
        chk("lsr4", opr2, 32'h08000000);
        op_reg2 = 4'd5; sft_reg = 8'h22;
        step();
        chk("lsl4", opr2, 32'h00000500);
        sft_reg = 8'h46;
        step();
        chk("ror8", opr2, 32'h50000000);
        sft_reg = 8'h17;
        step();
        chk("ror_by_r1", opr2, 32'h00500000);
        op_reg2 = 4'd3; sft_reg = 8'h04;
        step();
        chk("asr0_pass", opr2, 32'h80000000);

        op_reg1 = 4'd0; op_reg2 = 4'd0; sft_reg = 8'h22;
        fwd_en = 1; fwd_dest = 4'd0; fwd_data = 32'hAAAA;
        step();
        chk("r0_opr1", opr1, 32'd0);
        chk("r0_opr2", opr2, 32'd0);
        fwd_en = 0;

        imm_or_reg = 1; imm = 8'hAB; sft_imm = 4'd0;
        step();
        chk("imm_rot0", opr2, 32'h000000AB);
        sft_imm = 4'd15;
        step();
        chk("imm_rot30", opr2, 32'h000002AC);

        // forward beats write-back; write still lands
        imm = 8'h00; sft_imm = 4'd0; op_reg1 = 4'd2;
        fwd_en = 1; fwd_dest = 4'd2; fwd_data = 32'h1234;
        wb_en = 1; wb_addr = 4'd2; wb_data = 32'h5678;
        step();
        chk("fwd_prio", opr1, 32'h00001234);
        fwd_en = 0; wb_en = 0;
        step();
        chk("wb_landed", opr1, 32'h00005678);
        pos_show = 4'd2;
        step();
        step();
        chk("show_r2", {16'd0, show}, 32'h5678);
        wb_en = 1; wb_addr = 4'd4; wb_data = 32'hCAFE; op_reg1 = 4'd4;
        step();
        chk("wb_bypass", opr1, 32'h0000CAFE);
        wb_en = 0;

        // backpressure
        in_valid = 0;
        step();
        chk("bp_idle", {31'd0, out_valid}, 32'd0);
        out_ready = 0; in_valid = 1; op_code = 4'd1; dest = 4'd1; op_reg1 = 4'd1;
        step();
        chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_a_opcode", {28'd0, out_op_code}, 32'd1);
        op_code = 4'd2; dest = 4'd2; op_reg1 = 4'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_opcode", {28'd0, out_op_code}, 32'd1);
            chk("bp_hold_opr1", opr1, 32'h10);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_b_opcode", {28'd0, out_op_code}, 32'd2);
        chk("bp_b_opr1", opr1, 32'h60);
        chk("bp_b_valid", {31'd0, out_valid}, 32'd1);

        // flush with acceptance, write to r0
        op_code = 4'd3; flush = 1; wb_en = 1; wb_addr = 4'd0; wb_data = 32'hFFFF;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 0; wb_en = 0; in_valid = 0; pos_show = 4'd0;
        step();
        step();
        chk("r0_show", {16'd0, show}, 32'd0);

        out_ready = 0; in_valid = 1; op_code = 4'd4;
        step();
        chk("held_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 0; flush = 1;
        step();
        chk("flush_held", {31'd0, out_valid}, 32'd0);
        flush = 0;

        // reset mid-operation
        in_valid = 1; op_code = 4'd5; op_reg1 = 4'd1;
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        wb_en = 1; wb_addr = 4'd7; wb_data = 32'hDEAD; rst = 0;
        #2;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_opr1", opr1, 32'd0);
        chk("mid_rst_opcode", {28'd0, out_op_code}, 32'd0);
        rst = 1; wb_en = 0; in_valid = 0; out_ready = 1; pos_show = 4'd7;
        step();
        chk("rst_r7", {16'd0, show}, 32'h0070);
        pos_show = 4'd2;
        step();
        chk("rst_r2", {16'd0, show}, 32'h0020);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
